// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_perf_counters.sv
// Free-running fetch and stall event counters for the fetch unit; wrap at 2^32.
module ifu_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (fetch_inc) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall_inc) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding req/gnt/rvalid transaction feeding a one-entry IF/ID register.
// Define IFU_PERF_CNT_EN to add the fetch_cnt_o / stall_cnt_o performance counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter bit BYTE_ADDR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_i,
  output logic               pc_ready_o,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               flush_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [31:0]        id_pc_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  // Handshakes: a request transfers on the cycle imem_req_o && imem_gnt_i; read data is
  // taken on the cycle imem_rvalid_i is high while in WAIT; the IF/ID entry transfers on
  // the cycle id_valid_o && id_ready_i. The offering side holds its payload until transfer.

  ifu_state_e  state;
  logic        drop;
  logic [31:0] req_pc;
  logic        capture;

  assign imem_req_o  = (state == REQ);
  assign busy_o      = (state == WAIT);
  assign dbg_state_o = state;
  assign imem_addr_o = BYTE_ADDR ? ADDR_W'({pc_i, 2'b00}) : ADDR_W'(pc_i);

  assign capture    = (state == WAIT) && imem_rvalid_i && !drop && !flush_i;
  assign pc_ready_o = !rst && (state != IDLE) && (capture || flush_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drop       <= 1'b0;
      req_pc     <= 32'd0;
      id_valid_o <= 1'b0;
      id_instr_o <= NOP_INSTR;
      id_pc_o    <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          req_pc <= pc_i;
          if (imem_gnt_i) begin
            state <= WAIT;
            drop  <= flush_i;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            drop <= 1'b0;
            if (capture) begin
              id_instr_o <= imem_rdata_i;
              id_pc_o    <= req_pc;
              id_valid_o <= 1'b1;
              state      <= HOLD;
            end else begin
              state <= REQ;
            end
          end else if (flush_i) begin
            // The in-flight response belongs to the old path; remember to discard it.
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (flush_i || id_ready_i) begin
            id_valid_o <= 1'b0;
            state      <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush_i) begin
        id_valid_o <= 1'b0;
        id_instr_o <= NOP_INSTR;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = id_valid_o && id_ready_i;
  assign stall_inc = (state == REQ) || (state == WAIT) || ((state == HOLD) && !id_ready_i);

  ifu_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc   (fetch_inc),
    .stall_inc   (stall_inc),
    .fetch_cnt_o (fetch_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: memory/PC/decode environment, transaction-level model, scoreboard.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        busy_o;
  logic [1:0]  dbg_state;

  logic [31:0] pc_b;
  logic        zero_b;
  logic        pc_ready_b, req_b, id_valid_b, busy_b;
  logic [31:0] addr_b, instr_b, id_pc_b;
  logic [1:0]  dbg_state_b;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt_b, stall_cnt_b;
  logic [31:0] exp_fetch, exp_stall;
`endif

  instr_fetch_unit #(.ADDR_W(32), .BYTE_ADDR(1'b0)) u_dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_ready_o(pc_ready_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .flush_i(flush_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .busy_o(busy_o), .dbg_state_o(dbg_state)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  instr_fetch_unit #(.ADDR_W(32), .BYTE_ADDR(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .pc_i(pc_b), .pc_ready_o(pc_ready_b),
    .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_gnt_i(zero_b),
    .imem_rvalid_i(zero_b), .imem_rdata_i(pc_b), .flush_i(zero_b),
    .id_valid_o(id_valid_b), .id_ready_i(zero_b), .id_instr_o(instr_b),
    .id_pc_o(id_pc_b), .busy_o(busy_b), .dbg_state_o(dbg_state_b)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_b), .stall_cnt_o(stall_cnt_b)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];

  int gnt_pct, ready_pct, flush_pct, spur_pct, rv_min, rv_max;
  bit use_fixed, force_flush;
  logic [31:0] fixed_data, flush_target;

  bit outst, dropped, idle, pc_load;
  int rv_wait;
  logic [31:0] o_pc, o_data, pc_next, g_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit rv_during);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst           = 1'b1;
      flush_i       = 1'b0;
      id_ready_i    = 1'($urandom_range(0, 1));
      imem_gnt_i    = 1'b1;
      imem_rvalid_i = rv_during;
      imem_rdata_i  = 32'hBAD0BAD0;
      #1;
      if (i > 0) begin
        check("rst_req", imem_req_o, 1'b0);
        check("rst_pc_ready", pc_ready_o, 1'b0);
        check("rst_id_valid", id_valid_o, 1'b0);
        check("rst_id_instr", id_instr_o, 32'h00000013);
        check("rst_id_pc", id_pc_o, 32'd0);
        check("rst_busy", busy_o, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
      end
    end
    outst = 0; dropped = 0; idle = 1; pc_load = 0;
    exp_q.delete();
`ifdef IFU_PERF_CNT_EN
    exp_fetch = 0; exp_stall = 0;
`endif
  endtask

  task automatic step();
    bit deliver, holding, exp_req, grant;
    @(negedge clk);
    rst = 1'b0;
    if (pc_load) begin pc_i = pc_next; pc_load = 0; end
    flush_i     = !idle && (force_flush || ($urandom_range(0, 99) < flush_pct));
    force_flush = 0;
    id_ready_i  = ($urandom_range(0, 99) < ready_pct);
    imem_gnt_i  = ($urandom_range(0, 99) < gnt_pct);
    deliver     = outst && (rv_wait == 0);
    if (deliver) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = o_data;
    end else begin
      imem_rvalid_i = !outst && ($urandom_range(0, 99) < spur_pct);
      imem_rdata_i  = $urandom;
    end
    #1;
    holding = (exp_q.size() != 0);
    exp_req = !idle && !outst && !holding;
    check("imem_req", imem_req_o, exp_req);
    check("busy", busy_o, outst);
    check("id_valid", id_valid_o, holding);
    check("pc_ready", pc_ready_o, (deliver && !dropped && !flush_i) || flush_i);
    if (exp_req) check("imem_addr", imem_addr_o, pc_i);
    if (holding) check("id_hold", {id_pc_o, id_instr_o}, exp_q[0]);
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, exp_fetch);
    check("stall_cnt", stall_cnt, exp_stall);
    if (holding && id_ready_i) exp_fetch++;
    if (exp_req || outst || (holding && !id_ready_i)) exp_stall++;
`endif
    grant = exp_req && imem_gnt_i;
    if (flush_i && holding && !id_ready_i) exp_q.delete();
    if (deliver) begin
      if (!dropped && !flush_i) exp_q.push_back({o_pc, o_data});
      outst = 0;
    end else if (outst) begin
      rv_wait--;
      if (flush_i) dropped = 1;
    end
    if (grant) begin
      outst   = 1;
      dropped = flush_i;
      o_pc    = pc_i;
      o_data  = use_fixed ? fixed_data : $urandom;
      rv_wait = $urandom_range(rv_min, rv_max);
      g_addr  = imem_addr_o;
    end
    idle = 0;
    if (pc_ready_o) begin
      pc_load = 1;
      pc_next = flush_i ? flush_target : pc_i + 32'd1;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && id_valid_o && id_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_pop: got pc %h instr %h, expected no instruction", id_pc_o, id_instr_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {id_pc_o, id_instr_o}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst = 1'b1; pc_i = 32'h10; pc_b = 32'h5; zero_b = 1'b0;
    flush_i = 0; id_ready_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    gnt_pct = 100; ready_pct = 100; flush_pct = 0; spur_pct = 0; rv_min = 0; rv_max = 0;
    use_fixed = 1; fixed_data = 32'h00A00093; force_flush = 0; flush_target = 32'h40;

    // Minimum-latency fetch from pc 0x10.
    do_reset(1'b0);
    repeat (4) step();
    check("t1_instr", id_instr_o, 32'h00A00093);
    check("t1_pc", id_pc_o, 32'h10);

    // Grant held off three cycles.
    gnt_pct = 0;
    repeat (3) step();
    gnt_pct = 100;
    step();
    check("t2_gnt_addr", g_addr, 32'h11);

    check("byte_addr_req", req_b, 1'b1);
    check("byte_addr", addr_b, 32'h14);

    // Decode stalls for five cycles after capture.
    ready_pct = 0;
    guard = 0;
    while (exp_q.size() == 0 && guard < 20) begin step(); guard++; end
    check("t3_reach_hold", guard < 20, 1'b1);
    repeat (5) step();
    ready_pct = 100;
    repeat (2) step();

    // Flush while a response is outstanding; its data must be dropped.
    rv_min = 2; rv_max = 2; fixed_data = 32'hDEADBEEF;
    guard = 0;
    while (!outst && guard < 20) begin step(); guard++; end
    check("t4_reach_wait", outst, 1'b1);
    force_flush = 1; flush_target = 32'h40;
    step();
    fixed_data = 32'h00100113; rv_min = 0; rv_max = 0;
    guard = 0;
    while (!(outst && !dropped) && guard < 20) begin step(); guard++; end
    check("t4_redirect_addr", g_addr, 32'h40);
    repeat (3) step();

    // Reset mid-transaction with rvalid arriving during reset.
    rv_min = 3; rv_max = 3;
    guard = 0;
    while (!outst && guard < 20) begin step(); guard++; end
    check("t5_reach_wait", outst, 1'b1);
    do_reset(1'b1);
    repeat (3) step();

    // Random traffic.
    use_fixed = 0; gnt_pct = 50; ready_pct = 60; flush_pct = 8; spur_pct = 10;
    rv_min = 0; rv_max = 3;
    for (int i = 0; i < 2000; i++) begin
      flush_target = $urandom_range(0, 4095);
      step();
    end
    ready_pct = 100; flush_pct = 0;
    repeat (10) step();

    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage sitting directly downstream of the program counter register. Takes the current PC, issues a request/grant/response transaction to instruction memory, and holds the returned instruction plus its PC in a one-entry IF/ID output register for decode. It produces the PC's load-enable (pc_ready_o), so the PC advances only once per completed fetch or redirect.

Parameters:
ADDR_W, 32, width of imem_addr_o
BYTE_ADDR, 0, 0: imem_addr_o = pc_i (word address); 1: imem_addr_o = {pc_i, 2'b00} truncated to ADDR_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc_i  in  32  current PC (word address) from PC register
pc_ready_o  out  1  PC load-enable; single-cycle pulse
imem_req_o  out  1  memory request
imem_addr_o  out  ADDR_W  request address, stable while imem_req_o=1
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  32  instruction word
flush_i  in  1  redirect (taken branch/jump) from execute
id_valid_o  out  1  output register holds valid instruction
id_ready_i  in  1  decode accepts this cycle
id_instr_o  out  32  instruction to decode
id_pc_o  out  32  PC of id_instr_o
busy_o  out  1  transaction outstanding (state WAIT)

Behaviour:
- Reset: state IDLE; imem_req_o=0, pc_ready_o=0, id_valid_o=0, id_instr_o=NOP (32'h00000013), id_pc_o=0, busy_o=0, drop flag=0. Applies mid-transaction; any rvalid arriving after reset while not in WAIT is ignored.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: unconditionally -> REQ next cycle.
- REQ: imem_req_o=1, imem_addr_o from pc_i; req_pc latched every REQ cycle. On imem_gnt_i -> WAIT. Address/req held until grant.
- WAIT: busy_o=1. On imem_rvalid_i with drop=0: capture rdata -> id_instr_o, req_pc -> id_pc_o, id_valid_o=1 next cycle; pc_ready_o=1 that same cycle; -> HOLD. With drop=1: discard, clear drop, -> REQ, no pc_ready_o.
- HOLD: id_valid_o=1 until id_ready_i; on id_valid_o&&id_ready_i -> REQ, id_valid_o=0 next cycle. id_instr_o/id_pc_o stable while id_valid_o && !id_ready_i.
- Minimum latency: REQ with immediate gnt, rvalid the next cycle -> id_valid_o 2 cycles after REQ entry; throughput 1 instruction per 3 cycles with zero-wait memory and id_ready_i=1.
- pc_ready_o = capture | flush_i (combinational, one cycle per event); never asserted in IDLE or during rst.
- Flush (highest priority): next cycle id_valid_o=0, id_instr_o=NOP. In REQ: hold request if not yet granted (address re-sampled from redirected pc_i next cycle); if granted same cycle -> WAIT with drop=1. In WAIT: set drop=1 unless rvalid arrives same cycle (then discard directly) -> REQ. In HOLD: -> REQ. Flush coincident with capture: data discarded, pc_ready_o asserted once.
- Only one transaction outstanding; gnt outside REQ and rvalid outside WAIT are ignored.

Optional Feature:
Macro IFU_PERF_CNT_EN. Defined: adds outputs fetch_cnt_o[31:0] (increments per instruction accepted by decode) and stall_cnt_o[31:0] (increments each cycle in REQ/WAIT, or in HOLD with !id_ready_i); both reset to 0, wrap at 2^32. Undefined: ports and logic absent; no other behaviour changes.

Decomposition:
- Package ifu_pkg: ifu_state_e enum (IDLE, REQ, WAIT, HOLD), INSTR_W=32, NOP_INSTR=32'h00000013.
- Sub-module ifu_perf_counters (instantiated only under IFU_PERF_CNT_EN); FSM and output register remain in the top.

Test Plan:
- Reset release, pc_i=0x10, gnt immediate, rvalid next cycle rdata=0x00A00093 -> id_valid_o=1, id_instr_o=0x00A00093, id_pc_o=0x10; one pc_ready_o pulse.
- gnt delayed 3 cycles, pc_i held -> imem_req_o=1 and imem_addr_o=0x10 stable all 4 cycles; no pc_ready_o until rvalid.
- id_ready_i=0 for 5 cycles after capture -> id_* stable, no new imem_req_o; id_ready_i=1 -> REQ next cycle.
- flush_i in WAIT, then rvalid rdata=0xDEADBEEF -> word discarded, id_valid_o stays 0, new request at redirected pc_i=0x40.
- rst asserted in WAIT, rvalid arrives during rst -> all outputs at reset values, no capture; IDLE->REQ after release.
- BYTE_ADDR=1, pc_i=0x5 -> imem_addr_o=0x14.
